// File: rtl/regfile_wb_sb_if.sv
// Issue/writeback bus for regfile_wb_sb.
// The master drives read, issue and writeback requests; the slave returns read data and stall.
interface regfile_wb_sb_if #(
    parameter int unsigned DW = 32
);
    logic          rd_en;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic          iss_en;
    logic [4:0]    iss_rd;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          stall;

    modport master (
        output rd_en, rs1_addr, rs2_addr, iss_en, iss_rd, wb_en, wb_addr, wb_data,
        input  rs1_data, rs2_data, stall
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr, iss_en, iss_rd, wb_en, wb_addr, wb_data,
        output rs1_data, rs2_data, stall
    );
endinterface

// File: rtl/regfile_wb_sb.sv
// Writeback-side 32x32 register file with two registered read ports and a busy-bit scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_wb_sb #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input  logic           c,
    input  logic           rst_n,
    regfile_wb_sb_if.slave bus
);
    logic [DW-1:0]   r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [DW-1:0]   r_rs1_data;
    logic [DW-1:0]   r_rs2_data;

    logic          w_wb_live;
    logic          w_hit1;
    logic          w_hit2;
    logic          w_haz1;
    logic          w_haz2;
    logic          w_stall;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;

    assign w_wb_live = bus.wb_en && (bus.wb_addr != 5'd0);

`ifdef REGFILE_WB_BYPASS_EN
    assign w_hit1 = w_wb_live && (bus.wb_addr == bus.rs1_addr);
    assign w_hit2 = w_wb_live && (bus.wb_addr == bus.rs2_addr);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    // A source is hazardous while its producer is in flight, unless forwarded this cycle.
    assign w_haz1  = (bus.rs1_addr != 5'd0) && r_busy[bus.rs1_addr] && !w_hit1;
    assign w_haz2  = (bus.rs2_addr != 5'd0) && r_busy[bus.rs2_addr] && !w_hit2;
    assign w_stall = bus.rd_en && (w_haz1 || w_haz2);

    assign w_rd1 = w_hit1 ? bus.wb_data :
                   (bus.rs1_addr == 5'd0) ? '0 : r_mem[bus.rs1_addr];
    assign w_rd2 = w_hit2 ? bus.wb_data :
                   (bus.rs2_addr == 5'd0) ? '0 : r_mem[bus.rs2_addr];

    always_ff @(posedge c) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_mem[i] <= '0;
            end
            r_busy     <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            if (w_wb_live) begin
                r_mem[bus.wb_addr] <= bus.wb_data;
            end
            if (bus.rd_en && !w_stall) begin
                r_rs1_data <= w_rd1;
                r_rs2_data <= w_rd2;
            end
            // Clear before set so a new producer supersedes the completing one.
            if (w_wb_live) begin
                r_busy[bus.wb_addr] <= 1'b0;
            end
            if (bus.iss_en && !w_stall && (bus.iss_rd != 5'd0)) begin
                r_busy[bus.iss_rd] <= 1'b1;
            end
        end
    end

    assign bus.rs1_data = r_rs1_data;
    assign bus.rs2_data = r_rs2_data;
    assign bus.stall    = w_stall;
endmodule

// File: tb/tb_regfile_wb_sb.sv
// Directed-vector bench for regfile_wb_sb; expectations follow REGFILE_WB_BYPASS_EN when defined.
module tb_regfile_wb_sb;
    logic c;
    logic rst_n;
    int   n_vec;
    int   n_err;

    regfile_wb_sb_if #(.DW(32)) bus ();

    regfile_wb_sb #(.NREG(32), .DW(32)) dut (
        .c     (c),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.rd_en   = 1'b0;
        bus.iss_en  = 1'b0;
        bus.wb_en   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n        = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        bus.iss_en   = 1'b0;
        bus.iss_rd   = 5'd0;
        bus.wb_en    = 1'b0;
        bus.wb_addr  = 5'd0;
        bus.wb_data  = 32'h0;

        // 1: reset then read
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_rs1", bus.rs1_data, 32'h0);
        check("rst_rs2", bus.rs2_data, 32'h0);
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd5; bus.rs2_addr = 5'd0;
        #2 check("rst_stall", 32'(bus.stall), 32'h0);
        tick();
        check("rd5_after_rst", bus.rs1_data, 32'h0);
        check("rd0_after_rst", bus.rs2_data, 32'h0);
        for (int r = 1; r < 32; r++) begin
            bus.rs1_addr = 5'(r); bus.rs2_addr = 5'(r);
            #1 check($sformatf("busy_clear_r%0d", r), 32'(bus.stall), 32'h0);
        end
        tick();

        // 2: write then read, r0 write ignored, hold when rd_en=0
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'hDEADBEEF;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
        tick();
        check("rd7_rs1", bus.rs1_data, 32'hDEADBEEF);
        check("rd7_rs2_same", bus.rs2_data, 32'hDEADBEEF);
        idle();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h12345678;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd7;
        tick();
        check("rd_r0", bus.rs1_data, 32'h0);
        check("rd7_again", bus.rs2_data, 32'hDEADBEEF);
        idle();
        bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd0;
        tick();
        check("hold_rs1", bus.rs1_data, 32'h0);
        check("hold_rs2", bus.rs2_data, 32'hDEADBEEF);

        // 3: scoreboard hazard on r3
        bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
        #2 check("iss3_nostall", 32'(bus.stall), 32'h0);
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd3;
        #2 check("haz3_stall", 32'(bus.stall), 32'h1);
        tick();
        check("haz3_rs2_hold", bus.rs2_data, 32'hDEADBEEF);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hA5A5A5A5;
`ifdef REGFILE_WB_BYPASS_EN
        #2 check("wb3_stall_byp", 32'(bus.stall), 32'h0);
        tick();
        bus.wb_en = 1'b0;
`else
        #2 check("wb3_stall_nobyp", 32'(bus.stall), 32'h1);
        tick();
        check("wb3_rs2_hold", bus.rs2_data, 32'hDEADBEEF);
        bus.wb_en = 1'b0;
        #2 check("wb3_stall_clear", 32'(bus.stall), 32'h0);
        tick();
`endif
        check("rd3_data", bus.rs2_data, 32'hA5A5A5A5);
        check("rd3_rs1_zero", bus.rs1_data, 32'h0);

        // 4: set/clear collision on r9
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h11111111;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd0;
        #2 check("col9_stall", 32'(bus.stall), 32'h1);
        tick();
        check("col9_rs1_hold", bus.rs1_data, 32'h0);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99999999;
`ifdef REGFILE_WB_BYPASS_EN
        #2 check("col9_wb2_byp", 32'(bus.stall), 32'h0);
        tick();
        bus.wb_en = 1'b0;
`else
        #2 check("col9_wb2_nobyp", 32'(bus.stall), 32'h1);
        tick();
        check("col9_rs1_hold2", bus.rs1_data, 32'h0);
        bus.wb_en = 1'b0;
        #2 check("col9_stall_clear", 32'(bus.stall), 32'h0);
        tick();
`endif
        check("col9_data", bus.rs1_data, 32'h99999999);

        // 5: stall blocks issue of r12
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd2;
        tick();
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd2; bus.rs2_addr = 5'd0;
        bus.iss_en = 1'b1; bus.iss_rd = 5'd12;
        #2 check("blk_stall", 32'(bus.stall), 32'h1);
        tick();
        bus.iss_en = 1'b0;
        bus.rs1_addr = 5'd12;
        #2 check("blk_busy12_clear", 32'(bus.stall), 32'h0);
        bus.rd_en = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
        tick();
        idle();

        // 6: reset mid-flight on r4
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h55;
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd4;
        tick();
        idle();
        rst_n = 1'b0;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hFFFFFFFF;
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd9;
        tick();
        rst_n = 1'b1;
        idle();
        check("mid_rst_rs1", bus.rs1_data, 32'h0);
        check("mid_rst_rs2", bus.rs2_data, 32'h0);
        bus.rd_en = 1'b1; bus.rs1_addr = 5'd4; bus.rs2_addr = 5'd7;
        #2 check("mid_rst_nostall", 32'(bus.stall), 32'h0);
        tick();
        check("mid_rst_rd4", bus.rs1_data, 32'h0);
        check("mid_rst_rd7", bus.rs2_data, 32'h0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_sb.md
Name: regfile_wb_sb

Overview:
- Writeback-side register file for the 32-bit pipelined processor, directly downstream of the registered 32-bit writeback select mux.
- The mux output drives wb_data; this block commits it to a 32x32 register array.
- Provides two registered read ports to decode/issue.
- A busy-bit scoreboard raises stall when a source register still has a write in flight.

Parameters:
- NREG, 32, number of architectural registers (address width fixed at 5; NREG must be 32)
- DW, 32, data width

Ports:
- c  input  1  clock; all state updates on posedge c
- rst_n  input  1  synchronous active-low reset, sampled on posedge c
- rd_en  input  1  read request from issue stage this cycle
- rs1_addr  input  5  source register 1 address
- rs2_addr  input  5  source register 2 address
- rs1_data  output  32  registered read data, port 1
- rs2_data  output  32  registered read data, port 2
- iss_en  input  1  an instruction with a destination is issuing this cycle
- iss_rd  input  5  destination register of issuing instruction
- wb_en  input  1  writeback valid (aligned with registered wb mux output)
- wb_addr  input  5  writeback destination register
- wb_data  input  32  writeback data from the writeback mux
- stall  output  1  combinational; source operand not yet available

Behaviour:
- Reset (rst_n=0 at posedge c):
  - all array entries cleared to 0
  - busy[31:0] cleared to 0
  - rs1_data and rs2_data cleared to 0
  - reset overrides any simultaneous wb_en, iss_en or rd_en
  - reset mid-operation discards in-flight scoreboard state
- Register 0:
  - reads always return 0
  - writes to address 0 are ignored
  - busy[0] is never set
- Write:
  - on posedge c with wb_en=1 and wb_addr!=0, mem[wb_addr] <= wb_data
  - one write per cycle
- Read:
  - on posedge c with rd_en=1 and stall=0, rsN_data <= mem[rsN_addr], or 0 if rsN_addr=0
  - latency: one cycle from address to data
  - when rd_en=0 or stall=1, rs1_data and rs2_data hold their previous values
- Scoreboard:
  - set: on posedge c with iss_en=1, stall=0 and iss_rd!=0, busy[iss_rd] <= 1
  - clear: on posedge c with wb_en=1 and wb_addr!=0, busy[wb_addr] <= 0
  - simultaneous set and clear of the same index: set wins (a new producer supersedes the completing one)
  - iss_en while stall=1 is ignored; no busy bit changes
  - iss_en with rd_en=0 is legal and sets busy independently of the read port
- Stall: stall = rd_en & (hazN for N=1 or 2), where
  - hazN = (rsN_addr!=0) & busy[rsN_addr] & ~(bypass hit on rsN)
  - bypass hit: see Optional Feature
  - stall is combinational from the current inputs and busy state
  - stall does not depend on iss_en
- Same address on rs1 and rs2: both ports return identical data.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - a bypass hit on rsN is wb_en=1, wb_addr!=0 and wb_addr==rsN_addr in the same cycle as a read
  - on a hit, rsN_data <= wb_data (write-through) and hazN is suppressed
  - a register completing writeback is therefore readable in the same cycle with no stall
- Undefined:
  - no bypass; a same-cycle read returns the pre-write array value
  - hazN remains asserted while busy[rsN_addr]=1, so the reader stalls one extra cycle, until busy clears
  - read data is always the committed array value

Test Plan:
1. Reset then read:
   - rst_n=0 for 2 cycles, release, rd_en=1, rs1=5, rs2=0
   - -> rs1_data=0, rs2_data=0, stall=0, busy all 0
2. Write/read:
   - wb_en=1, wb_addr=7, wb_data=0xDEADBEEF; next cycle rd_en=1, rs1=7
   - -> rs1_data=0xDEADBEEF one cycle after the read
   - wb to addr 0 with 0x12345678, then read r0 -> 0
3. Scoreboard hazard:
   - iss_en=1, iss_rd=3; next cycle rd_en=1, rs2=3 -> stall=1 and rs2_data holds
   - wb_en=1, addr 3, data 0xA5A5A5A5 -> with bypass: stall=0 that cycle and rs2_data=0xA5A5A5A5 next edge
   - without bypass: stall clears one cycle later, then same data
4. Set/clear collision:
   - busy[9]=1; same cycle iss_en=1, iss_rd=9, wb_en=1, wb_addr=9
   - -> busy[9] stays 1; a later read of r9 stalls until a second wb to 9
5. Stall blocks issue:
   - stall=1 with iss_en=1, iss_rd=12 -> busy[12] remains 0
6. Reset mid-flight:
   - busy[4]=1 and mem[4]=0x55; assert rst_n=0 for 1 cycle concurrent with wb_en to r4
   - -> busy[4]=0, mem[4]=0, no write
   - subsequent read of r4 returns 0 without stall
